uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Configurable UART receiver; the next generation of the fixed 8N1 receiver used with the MATLAB GUI link.
- Generalised in data width, parity mode and stop-bit count.
- Adds three-sample majority voting, false-start rejection, parity/framing error reporting and a one-cycle valid strobe.
- Sits between the board RX pin and command-decode logic, on the single system clock.

Parameters:
CLK_BAUD, 870, clock cycles per bit period; must be >= 8.
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
PARITY_MODE, 0, parity selection: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
CLK  input  1  system clock
RST_N  input  1  reset; asynchronous assert, active-low
RX  input  1  serial line, idle high; asynchronous to CLK
out_bits  output  DATA_BITS  last received word
out_valid  output  1  one-cycle strobe: new word on out_bits
parity_err  output  1  parity mismatch on last word
frame_err  output  1  stop bit sampled low on last word
busy  output  1  high whenever FSM is not in IDLE

Behaviour:
- Clock and reset (already decided): one clock, CLK; RST_N is asynchronous and active-low.
- Reset values: synchroniser flops 1, state IDLE, counters 0, out_bits 0, out_valid 0, parity_err 0, frame_err 0, busy 0.
- Reset mid-frame: frame is discarded; no strobe is emitted.
- Synchroniser: RX passes through 2 flops. All logic below uses the synchronised value rxs.
- Majority vote: a bit's value is the majority of rxs at counts CLK_BAUD-3, CLK_BAUD-2 and CLK_BAUD-1 of its bit period. The count restarts at 0 for each bit.
- States:
  - IDLE: count=0, bit index=0. rxs==0 -> START.
  - START: count runs to (CLK_BAUD-1)/2. At that count, if rxs==1 -> IDLE (false start, no flags, no strobe); else count=0 -> DATA.
  - DATA: one majority sample per bit period, stored to shift register position bit index. After bit DATA_BITS-1: -> PARITY if PARITY_MODE!=0, else -> STOP.
  - PARITY: one period; captures the voted parity bit.
  - STOP: STOP_BITS periods. Any stop sample voted 0 sets the frame-error flag for this frame.
  - DONE: one cycle.
    - out_bits <= shift register.
    - out_valid=1.
    - parity_err <= (XOR of data bits ^ parity bit) != (PARITY_MODE==1); always 0 when PARITY_MODE==0.
    - frame_err <= frame-error flag.
    - Next state: BREAK if the frame-error flag is set, else IDLE.
  - BREAK: wait until rxs==1, then -> IDLE. A line held low never produces repeated frames.
  - Undefined encodings -> IDLE.
- Latency: out_valid rises one cycle after the final stop-bit sample. Total from start edge at pin ≈ 2 + (CLK_BAUD-1)/2 + (DATA_BITS + parity + STOP_BITS)·CLK_BAUD + 1 cycles.
- Output hold: out_bits, parity_err and frame_err hold until the next DONE. Errored words are still delivered, with out_valid=1.
- Back-to-back frames: a new start bit immediately after the last stop period is accepted. IDLE is entered in the cycle after DONE and checks rxs that same cycle.
- Width rules: count is $clog2(CLK_BAUD) bits. Bit index is $clog2(DATA_BITS) bits and is compared against DATA_BITS-1; it never wraps.

Decomposition:
- Package uart_pkg:
  - state encodings (IDLE, START, DATA, PARITY, STOP, DONE, BREAK; 3 bits);
  - parity-mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
- One sub-module, uart_rx_sampler: 2-flop synchroniser plus 3-sample majority register. Inputs: CLK, RST_N, RX, sample enables. Outputs: rxs, voted bit.
- The FSM and datapath stay in uart_rx_cfg.

Test Plan:
1. CLK_BAUD=16, 8N1; send 0x55 -> one out_valid pulse, out_bits=0x55, parity_err=0, frame_err=0, busy low two cycles after the strobe.
2. PARITY_MODE=2, send 0xA3 with parity bit 1 -> out_bits=0xA3, parity_err=1. Resend with parity bit 0 -> parity_err=0.
3. 8N1, send 0x3C with stop bit 0, then hold RX low 100 cycles -> out_valid once, frame_err=1, busy stays high until RX returns high, no further strobes.
4. RX low pulse of 3 cycles on an idle line -> no out_valid; busy returns low after about 8+2 cycles. A 1-cycle glitch inside a data bit, off the vote window -> word unaffected.
5. DATA_BITS=7, STOP_BITS=2, PARITY_MODE=1; back-to-back 0x41, 0x7F with no idle gap -> two strobes, values 0x41 then 0x7F, no errors.
6. Assert RST_N low mid-DATA of a frame -> all outputs return to reset values immediately. The partial frame produces no strobe; the next full frame 0x96 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM state encodings,
// parity-mode constants and the 3-sample majority helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5,
    ST_BREAK  = 3'd6
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX pin synchroniser and majority-vote window; the vote combines the two
// stored window samples with the live synchronised value.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic RX,
  input  logic sample_en,
  output logic rxs,
  output logic voted
);

  logic       r_sync1;
  logic       r_sync2;
  logic [1:0] r_win;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_win   <= 2'b11;
    end else begin
      r_sync1 <= RX;
      r_sync2 <= r_sync1;
      if (sample_en)
        r_win <= {r_win[0], r_sync2};
    end
  end

  assign rxs   = r_sync2;
  assign voted = maj3({r_win, r_sync2});

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: start validation, voted data/parity/stop sampling,
// error flags and a one-cycle strobe; holds off after a framing error until idle.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_BAUD    = 870,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] out_bits,
  output logic                 out_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLK_BAUD);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_BAUD - 1);
  localparam logic [CW-1:0] CNT_V0    = CW'(CLK_BAUD - 3);
  localparam logic [CW-1:0] CNT_V1    = CW'(CLK_BAUD - 2);
  localparam logic [CW-1:0] CNT_MID   = CW'((CLK_BAUD - 1) / 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_ferr_flag;
  logic [DATA_BITS-1:0] r_out_bits;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;

  logic w_rxs;
  logic w_voted;
  logic w_sample_en;
  logic w_bit_end;
  logic w_busy;
  logic w_ferr_new;

  function automatic logic parity_error(input logic [DATA_BITS-1:0] data,
                                        input logic                 pbit);
    logic x;
    x = (^data) ^ pbit;
    case (PARITY_MODE)
      PAR_ODD:  parity_error = ~x;
      PAR_EVEN: parity_error = x;
      default:  parity_error = 1'b0;
    endcase
  endfunction

  uart_rx_sampler u_sampler (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .RX        (RX),
    .sample_en (w_sample_en),
    .rxs       (w_rxs),
    .voted     (w_voted)
  );

  assign w_bit_end  = (r_cnt == CNT_LAST);
  assign w_ferr_new = r_ferr_flag | ~w_voted;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_sample_en = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (!w_rxs)
          w_next = ST_START;
      end
      ST_START: begin
        if (r_cnt == CNT_MID)
          w_next = w_rxs ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        w_sample_en = (r_cnt == CNT_V0) || (r_cnt == CNT_V1);
        if (w_bit_end && (r_idx == IDX_LAST))
          w_next = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        w_sample_en = (r_cnt == CNT_V0) || (r_cnt == CNT_V1);
        if (w_bit_end)
          w_next = ST_STOP;
      end
      ST_STOP: begin
        w_sample_en = (r_cnt == CNT_V0) || (r_cnt == CNT_V1);
        if (w_bit_end && (r_idx == STOP_LAST))
          w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = r_ferr_flag ? ST_BREAK : ST_IDLE;
      end
      ST_BREAK: begin
        if (w_rxs)
          w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Results are latched on the final stop sample so the strobe and word appear together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_par_bit   <= 1'b0;
      r_ferr_flag <= 1'b0;
      r_out_bits  <= '0;
      r_valid     <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_START: begin
          if (r_cnt == CNT_MID)
            r_cnt <= '0;
          else
            r_cnt <= r_cnt + CW'(1);
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_voted;
            if (r_idx == IDX_LAST)
              r_idx <= '0;
            else
              r_idx <= r_idx + IW'(1);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_par_bit <= w_voted;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_cnt       <= '0;
            r_ferr_flag <= w_ferr_new;
            if (r_idx == STOP_LAST) begin
              r_idx      <= '0;
              r_out_bits <= r_shift;
              r_valid    <= 1'b1;
              r_perr     <= parity_error(r_shift, r_par_bit);
              r_ferr     <= w_ferr_new;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (r_state == ST_IDLE)
            r_ferr_flag <= 1'b0;
        end
      endcase
    end
  end

  assign out_bits   = r_out_bits;
  assign out_valid  = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = w_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three receiver configurations share one driven line,
// exercised by a vector table, corner-case sequences and randomized frames.
module tb_uart_rx_cfg;

  localparam int BAUD = 16;

  typedef struct packed {
    logic [8:0] bits;
    logic       perr;
    logic       ferr;
  } rec_t;

  typedef struct {
    int         d;
    logic [8:0] data;
    logic       pbit;
    logic       stopv;
    logic [8:0] eb;
    logic       ep;
    logic       ef;
  } vec_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic rx_line = 1'b1;
  int   sel     = 0;

  logic       rx_a, rx_b, rx_c;
  logic [7:0] bits_a, bits_b;
  logic [6:0] bits_c;
  logic ov_a, pe_a, fe_a, bz_a;
  logic ov_b, pe_b, fe_b, bz_b;
  logic ov_c, pe_c, fe_c, bz_c;

  int cfg_nbits [3] = '{8, 8, 7};
  int cfg_mode  [3] = '{0, 2, 1};
  int cfg_nstop [3] = '{1, 1, 2};

  rec_t q0[$];
  rec_t q1[$];
  rec_t q2[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rx_a = (sel == 0) ? rx_line : 1'b1;
  assign rx_b = (sel == 1) ? rx_line : 1'b1;
  assign rx_c = (sel == 2) ? rx_line : 1'b1;

  uart_rx_cfg #(.CLK_BAUD(BAUD), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
    .CLK(clk), .RST_N(rst_n), .RX(rx_a), .out_bits(bits_a), .out_valid(ov_a),
    .parity_err(pe_a), .frame_err(fe_a), .busy(bz_a));

  uart_rx_cfg #(.CLK_BAUD(BAUD), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_b (
    .CLK(clk), .RST_N(rst_n), .RX(rx_b), .out_bits(bits_b), .out_valid(ov_b),
    .parity_err(pe_b), .frame_err(fe_b), .busy(bz_b));

  uart_rx_cfg #(.CLK_BAUD(BAUD), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_c (
    .CLK(clk), .RST_N(rst_n), .RX(rx_c), .out_bits(bits_c), .out_valid(ov_c),
    .parity_err(pe_c), .frame_err(fe_c), .busy(bz_c));

  function automatic rec_t mk(input logic [8:0] b, input logic p, input logic f);
    rec_t r;
    r.bits = b;
    r.perr = p;
    r.ferr = f;
    return r;
  endfunction

  always @(negedge clk) begin
    if (ov_a) q0.push_back(mk({1'b0, bits_a}, pe_a, fe_a));
    if (ov_b) q1.push_back(mk({1'b0, bits_b}, pe_b, fe_b));
    if (ov_c) q2.push_back(mk({2'b00, bits_c}, pe_c, fe_c));
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic rec_t qpop(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Drives one frame on the line for receiver d; the line is left at the last stop value.
  task automatic send_frame(input int d, input logic [8:0] data, input logic pbit,
                            input logic stopv, input int glitch);
    logic [15:0] fr;
    int          len;
    fr     = '1;
    fr[0]  = 1'b0;
    len    = 1;
    for (int i = 0; i < cfg_nbits[d]; i++) begin
      fr[len] = data[i];
      len++;
    end
    if (cfg_mode[d] != 0) begin
      fr[len] = pbit;
      len++;
    end
    for (int i = 0; i < cfg_nstop[d]; i++) begin
      fr[len] = stopv;
      len++;
    end
    sel = d;
    for (int b = 0; b < len; b++) begin
      for (int c = 0; c < BAUD; c++) begin
        @(negedge clk);
        rx_line = ((b * BAUD + c) == glitch) ? ~fr[b] : fr[b];
      end
    end
  endtask

  task automatic expect_word(input int d, input int cnt, input logic [8:0] eb,
                             input logic ep, input logic ef, input string nm);
    rec_t r;
    chk({nm, " strobe count"}, qsize(d), cnt);
    if (qsize(d) > 0) begin
      r = qpop(d);
      chk({nm, " out_bits"}, r.bits, eb);
      chk({nm, " parity_err"}, r.perr, ep);
      chk({nm, " frame_err"}, r.ferr, ef);
    end
    if (cnt == 1) begin
      chk({nm, " stray strobes"}, q0.size() + q1.size() + q2.size(), 0);
      q0.delete();
      q1.delete();
      q2.delete();
    end
  endtask

  function automatic logic model_perr(input int d, input logic [8:0] data, input logic pbit);
    int ones;
    ones = $countones(data) + int'(pbit);
    if (cfg_mode[d] == 1) return (ones % 2) == 0;
    if (cfg_mode[d] == 2) return (ones % 2) == 1;
    return 1'b0;
  endfunction

  vec_t tv[10];

  initial begin
    int         seen;
    int         cnt;
    int         d;
    int         gap;
    logic [8:0] data;
    logic [8:0] m;
    logic       pbit;
    logic       stopv;

    tv[0] = '{0, 9'h055, 1'b0, 1'b1, 9'h055, 1'b0, 1'b0};
    tv[1] = '{1, 9'h0A3, 1'b1, 1'b1, 9'h0A3, 1'b1, 1'b0};
    tv[2] = '{1, 9'h0A3, 1'b0, 1'b1, 9'h0A3, 1'b0, 1'b0};
    tv[3] = '{2, 9'h041, 1'b1, 1'b0, 9'h041, 1'b0, 1'b1};
    tv[4] = '{2, 9'h07F, 1'b0, 1'b1, 9'h07F, 1'b0, 1'b0};
    tv[5] = '{2, 9'h041, 1'b0, 1'b1, 9'h041, 1'b1, 1'b0};
    tv[6] = '{1, 9'h000, 1'b1, 1'b1, 9'h000, 1'b1, 1'b0};
    tv[7] = '{0, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0};
    tv[8] = '{1, 9'h081, 1'b0, 1'b0, 9'h081, 1'b0, 1'b1};
    tv[9] = '{2, 9'h000, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset a", {ov_a, pe_a, fe_a, bz_a, bits_a}, 0);
    chk("reset b", {ov_b, pe_b, fe_b, bz_b, bits_b}, 0);
    chk("reset c", {ov_c, pe_c, fe_c, bz_c, bits_c}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle busy", {bz_a, bz_b, bz_c}, 0);

    for (int i = 0; i < 10; i++) begin
      send_frame(tv[i].d, tv[i].data, tv[i].pbit, tv[i].stopv, -1);
      rx_line = 1'b1;
      repeat (6) @(negedge clk);
      expect_word(tv[i].d, 1, tv[i].eb, tv[i].ep, tv[i].ef, $sformatf("vec%0d", i));
    end

    // Strobe width and busy release after the strobe.
    fork
      send_frame(0, 9'h055, 1'b0, 1'b1, -1);
      begin
        seen = 0;
        for (int i = 0; i < 20 * BAUD && seen == 0; i++) begin
          @(negedge clk);
          if (ov_a) seen = 1;
        end
        chk("t1 strobe seen", seen, 1);
        if (seen == 1) begin
          @(negedge clk);
          chk("t1 strobe width", ov_a, 0);
          @(negedge clk);
          chk("t1 busy after strobe", bz_a, 0);
        end
      end
    join
    repeat (4) @(negedge clk);
    expect_word(0, 1, 9'h055, 1'b0, 1'b0, "t1");

    // Framing error followed by a line held low.
    send_frame(0, 9'h03C, 1'b0, 1'b0, -1);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bz_a) cnt++;
    end
    chk("t3 busy held in break", cnt, 0);
    expect_word(0, 1, 9'h03C, 1'b0, 1'b1, "t3");
    rx_line = 1'b1;
    repeat (6) @(negedge clk);
    chk("t3 busy released", bz_a, 0);
    chk("t3 no further strobe", q0.size(), 0);

    // False start: 3-cycle low pulse.
    sel = 0;
    repeat (3) begin
      @(negedge clk);
      rx_line = 1'b0;
    end
    @(negedge clk);
    rx_line = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bz_a) cnt++;
    end
    chk("t4 false start busy width ok", (cnt >= 6 && cnt <= 12), 1);
    chk("t4 busy low", bz_a, 0);
    chk("t4 no strobe", q0.size(), 0);

    // Single-cycle glitches off and inside the vote window.
    send_frame(0, 9'h0C5, 1'b0, 1'b1, 3 * BAUD + 2);
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    expect_word(0, 1, 9'h0C5, 1'b0, 1'b0, "t4 glitch off window");
    for (int k = 0; k < 3; k++) begin
      send_frame(0, 9'h0C5, 1'b0, 1'b1, (4 + k) * BAUD + 6 + k);
      rx_line = 1'b1;
      repeat (4) @(negedge clk);
      expect_word(0, 1, 9'h0C5, 1'b0, 1'b0, $sformatf("t4 glitch vote%0d", k));
    end

    // Back-to-back frames, 7 bits, odd parity, 2 stop bits.
    send_frame(2, 9'h041, 1'b1, 1'b1, -1);
    send_frame(2, 9'h07F, 1'b0, 1'b1, -1);
    rx_line = 1'b1;
    repeat (6) @(negedge clk);
    expect_word(2, 2, 9'h041, 1'b0, 1'b0, "t5 first");
    expect_word(2, 1, 9'h07F, 1'b0, 1'b0, "t5 second");

    // Reset asserted mid-DATA.
    fork
      send_frame(0, 9'h05A, 1'b0, 1'b1, -1);
      begin
        repeat (5 * BAUD) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6 reset a outputs", {ov_a, pe_a, fe_a, bz_a, bits_a}, 0);
        chk("t6 reset c outputs", {ov_c, pe_c, fe_c, bz_c, bits_c}, 0);
      end
    join
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6 no strobe from partial frame", q0.size(), 0);
    send_frame(0, 9'h096, 1'b0, 1'b1, -1);
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    expect_word(0, 1, 9'h096, 1'b0, 1'b0, "t6 after reset");

    // Randomized frames against the reference model.
    for (int i = 0; i < 40; i++) begin
      d     = $urandom_range(0, 2);
      m     = 9'((1 << cfg_nbits[d]) - 1);
      data  = 9'($urandom) & m;
      pbit  = 1'($urandom);
      stopv = ($urandom_range(0, 9) != 0);
      gap   = stopv ? $urandom_range(0, 8) : $urandom_range(4, 12);
      send_frame(d, data, pbit, stopv, -1);
      rx_line = 1'b1;
      expect_word(d, 1, data, model_perr(d, data, pbit), ~stopv, $sformatf("rnd%0d", i));
      repeat (gap) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
